sort16_frame_ctrl: RTL and testbench

Frame sequencer that sits directly upstream of the top-16 sort/sum stage and owns its control pins. It accepts a valid/ready sample stream delimited by `in_last` and clears the sorter before each frame. It feeds accepted samples to the sorter, waits out the sorter's register latency, then captures the frame result (max, top-16 sum, mean, sample count) into a held output with a valid/ready handshake.

---
 rtl/sort16_frame_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_sort16_frame_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort16_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sort16_frame_ctrl
//
// Frame sequencer for the top-16 sort/sum stage. It clears the sorter before
// every frame, streams accepted samples into it, waits for the sorter's
// register latency (data regs, then the registered sum), and then holds the
// frame result behind a valid/ready handshake until it is consumed.
//
// Optional feature macro: SORT16_FRAME_TIMEOUT_EN
//   defined   : an idle counter closes a started frame after TIMEOUT_CYC
//               consecutive cycles without a sample; out_timeout flags it.
//   undefined : frames end only on in_last; out_timeout is tied to 0.
//
// Ports
//   clk          sole clock, rising edge
//   synrst       synchronous active-high reset
//   in_valid     sample present
//   in_data      unsigned sample [W-1:0]
//   in_last      last sample of the frame (qualified by in_valid)
//   in_ready     sample accepted when in_valid & in_ready
//   sort_rst     sorter synrst
//   sort_en      sorter DataEn
//   sort_data    sorter DataIn
//   sort_max     sorter DataMax [W-1:0]
//   sort_sum     sorter DataSumOut [W+3:0], registered one cycle after its data
//   out_valid    frame result available
//   out_ready    result consumed when out_valid & out_ready
//   out_max      captured sort_max
//   out_sum      captured sort_sum
//   out_mean     floor(out_sum / 16)
//   out_count    accepted samples in frame, saturating at 16'hFFFF
//   out_short    frame had fewer than 16 samples (sum includes zero slots)
//   out_timeout  frame closed by idle timeout rather than in_last
// -----------------------------------------------------------------------------
module sort16_frame_ctrl #(
    parameter int W           = 12,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic         clk,
    input  logic         synrst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         sort_rst,
    output logic         sort_en,
    output logic [W-1:0] sort_data,
    input  logic [W-1:0] sort_max,
    input  logic [W+3:0] sort_sum,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_max,
    output logic [W+3:0] out_sum,
    output logic [W-1:0] out_mean,
    output logic [15:0]  out_count,
    output logic         out_short,
    output logic         out_timeout
);

    typedef enum logic [2:0] {
        S_CLEAR  = 3'd0,
        S_RUN    = 3'd1,
        S_DRAIN1 = 3'd2,
        S_DRAIN2 = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t       state_q, state_d;
    logic [15:0]  count_q, count_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_max_q, out_max_d;
    logic [W+3:0] out_sum_q, out_sum_d;
    logic [15:0]  out_count_q, out_count_d;
    logic         out_short_q, out_short_d;
    logic         accept;

`ifdef SORT16_FRAME_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              timeout_q, timeout_d;
    logic              out_timeout_q, out_timeout_d;
`else
    // Parameter only matters when the idle timeout is built in.
    logic timeout_cfg_unused;
    assign timeout_cfg_unused = (TIMEOUT_CYC > 0);
`endif

    // in_ready depends on state only, never on in_valid/out_ready.
    assign in_ready  = (state_q == S_RUN);
    assign accept    = in_valid & in_ready;
    assign sort_en   = accept;
    assign sort_data = in_data;
    assign sort_rst  = synrst | (state_q == S_CLEAR);

    assign out_valid = out_valid_q;
    assign out_max   = out_max_q;
    assign out_sum   = out_sum_q;
    assign out_mean  = out_sum_q[W+3:4];
    assign out_count = out_count_q;
    assign out_short = out_short_q;
`ifdef SORT16_FRAME_TIMEOUT_EN
    assign out_timeout = out_timeout_q;
`else
    assign out_timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_max_d   = out_max_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_short_d = out_short_q;
`ifdef SORT16_FRAME_TIMEOUT_EN
        idle_d        = idle_q;
        timeout_d     = timeout_q;
        out_timeout_d = out_timeout_q;
`endif
        case (state_q)
            S_CLEAR: begin
                count_d = '0;
`ifdef SORT16_FRAME_TIMEOUT_EN
                idle_d    = '0;
                timeout_d = 1'b0;
`endif
                state_d = S_RUN;
            end
            S_RUN: begin
                if (accept) begin
                    // Count saturates; the sorter keeps taking samples.
                    count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
`ifdef SORT16_FRAME_TIMEOUT_EN
                    idle_d = '0;
`endif
                    if (in_last) begin
                        state_d = S_DRAIN1;
                    end
                end
`ifdef SORT16_FRAME_TIMEOUT_EN
                // A frame with no samples yet never times out; count only
                // returns to zero through CLEAR, so it marks a started frame.
                else if (count_q != 16'd0) begin
                    idle_d = idle_q + IDLE_W'(1);
                    if (idle_q == IDLE_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = S_DRAIN1;
                    end
                end
`endif
            end
            S_DRAIN1: begin
                state_d = S_DRAIN2;
            end
            S_DRAIN2: begin
                // sort_sum has settled by now (data regs, then sum reg).
                out_valid_d = 1'b1;
                out_max_d   = sort_max;
                out_sum_d   = sort_sum;
                out_count_d = count_q;
                out_short_d = (count_q < 16'd16);
`ifdef SORT16_FRAME_TIMEOUT_EN
                out_timeout_d = timeout_q;
`endif
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_CLEAR;
                end
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (synrst) begin
            state_q     <= S_CLEAR;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_max_q   <= '0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_short_q <= 1'b0;
`ifdef SORT16_FRAME_TIMEOUT_EN
            idle_q        <= '0;
            timeout_q     <= 1'b0;
            out_timeout_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_max_q   <= out_max_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_short_q <= out_short_d;
`ifdef SORT16_FRAME_TIMEOUT_EN
            idle_q        <= idle_d;
            timeout_q     <= timeout_d;
            out_timeout_q <= out_timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_sort16_frame_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for sort16_frame_ctrl. Includes a behavioural top-16 sorter that
// the DUT drives, and a frame-level reference model (max, sum of the 16
// largest samples, count, short flag) computed from the samples sent.
// -----------------------------------------------------------------------------
module tb_sort16_frame_ctrl;
    localparam int W  = 12;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         synrst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         in_ready;
    logic         sort_rst;
    logic         sort_en;
    logic [W-1:0] sort_data;
    logic [W-1:0] sort_max;
    logic [W+3:0] sort_sum;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_max;
    logic [W+3:0] out_sum;
    logic [W-1:0] out_mean;
    logic [15:0]  out_count;
    logic         out_short;
    logic         out_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int en_cnt   = 0;

    logic [W-1:0] frame_q[$];

    always #5 clk = ~clk;

    sort16_frame_ctrl #(.W(W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .synrst(synrst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .sort_rst(sort_rst), .sort_en(sort_en), .sort_data(sort_data),
        .sort_max(sort_max), .sort_sum(sort_sum),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_max(out_max), .out_sum(out_sum), .out_mean(out_mean),
        .out_count(out_count), .out_short(out_short), .out_timeout(out_timeout)
    );

    // Behavioural sorter: 16 slots kept in descending order, max is slot 0,
    // sum registered one cycle after the slots.
    logic [W-1:0] sm_top [16];
    logic [W-1:0] sm_nt [16];
    logic [W-1:0] sm_v, sm_t;
    logic [W+3:0] sm_s, sm_sum;
    assign sort_max = sm_top[0];
    assign sort_sum = sm_sum;

    always @(posedge clk) begin
        if (sort_en) en_cnt <= en_cnt + 1;
        if (sort_rst) begin
            for (int i = 0; i < 16; i++) sm_top[i] <= '0;
            sm_sum <= '0;
        end else begin
            sm_s = '0;
            for (int i = 0; i < 16; i++) sm_s = sm_s + (W+4)'(sm_top[i]);
            sm_sum <= sm_s;
            if (sort_en) begin
                sm_nt = sm_top;
                sm_v  = sort_data;
                for (int i = 0; i < 16; i++) begin
                    if (sm_v > sm_nt[i]) begin
                        sm_t = sm_nt[i]; sm_nt[i] = sm_v; sm_v = sm_t;
                    end
                end
                sm_top <= sm_nt;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (time %0t, limit 2000000)", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample (optionally after a random idle gap) until accepted.
    task automatic send(input logic [W-1:0] d, input bit last, input bit gaps);
        bit acc;
        int guard;
        int g;
        if (gaps) begin
            g = $urandom_range(0, 3);
            repeat (g) begin
                in_valid = 1'b0;
                in_last  = 1'($urandom_range(0, 1));
                in_data  = W'($urandom);
                tick();
            end
        end
        in_valid = 1'b1; in_data = d; in_last = last;
        acc = 1'b0; guard = 0;
        while (!acc && guard < 50) begin
            acc = in_ready;
            tick();
            guard++;
        end
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_accept: in_ready never seen, got %0b required 1", acc);
        end else begin
            frame_q.push_back(d);
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Compare the held outputs with a frame-level model of the sent samples.
    task automatic check_result(input string name, input bit exp_to);
        logic [W-1:0] s[$];
        logic [W-1:0] e_max;
        logic [W+3:0] e_sum;
        logic [15:0]  e_cnt;
        bit           e_short;
        s = frame_q;
        s.rsort();
        e_max = (s.size() > 0) ? s[0] : '0;
        e_sum = '0;
        for (int i = 0; i < s.size() && i < 16; i++) e_sum = e_sum + (W+4)'(s[i]);
        e_cnt   = (s.size() > 65535) ? 16'hFFFF : 16'(s.size());
        e_short = (s.size() < 16);
        n_checks++; if (out_max !== e_max) begin n_fail++; $display("FAIL %s out_max: got %0d required %0d", name, out_max, e_max); end
        n_checks++; if (out_sum !== e_sum) begin n_fail++; $display("FAIL %s out_sum: got %0d required %0d", name, out_sum, e_sum); end
        n_checks++; if (out_mean !== W'(e_sum / 16)) begin n_fail++; $display("FAIL %s out_mean: got %0d required %0d", name, out_mean, e_sum / 16); end
        n_checks++; if (out_count !== e_cnt) begin n_fail++; $display("FAIL %s out_count: got %0d required %0d", name, out_count, e_cnt); end
        n_checks++; if (out_short !== e_short) begin n_fail++; $display("FAIL %s out_short: got %0b required %0b", name, out_short, e_short); end
        n_checks++; if (out_timeout !== exp_to) begin n_fail++; $display("FAIL %s out_timeout: got %0b required %0b", name, out_timeout, exp_to); end
    endtask

    // Entered just after the edge that moved the FSM into DRAIN1.
    task automatic finish_frame(input string name, input int hold, input bit exp_to);
        logic [W-1:0] mx;
        logic [W+3:0] sm;
        logic [15:0]  cn;
        in_valid = 1'b1; in_last = 1'b1; in_data = W'($urandom); #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s drain%0d out_valid: got %0b required 0", name, k + 1, out_valid); end
            n_checks++; if ({in_ready, sort_en} !== 2'b00) begin n_fail++; $display("FAIL %s drain%0d in_ready/sort_en: got %b required 00", name, k + 1, {in_ready, sort_en}); end
            tick();
        end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s latency out_valid: got %0b required 1", name, out_valid); end
        check_result(name, exp_to);
        repeat (hold) begin
            mx = out_max; sm = out_sum; cn = out_count;
            tick();
            n_checks++;
            if ({out_valid, in_ready, sort_en} !== 3'b100 || out_max !== mx || out_sum !== sm || out_count !== cn) begin
                n_fail++;
                $display("FAIL %s hold: got valid/rdy/en=%b max=%0d sum=%0d cnt=%0d required 100 %0d %0d %0d",
                         name, {out_valid, in_ready, sort_en}, out_max, out_sum, out_count, mx, sm, cn);
            end
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        tick();
        n_checks++; if ({out_valid, sort_rst, in_ready} !== 3'b010) begin n_fail++; $display("FAIL %s clear: got valid/sort_rst/rdy=%b required 010", name, {out_valid, sort_rst, in_ready}); end
        out_ready = 1'b0;
        tick();
        n_checks++; if ({sort_rst, in_ready} !== 2'b01) begin n_fail++; $display("FAIL %s rerun: got sort_rst/rdy=%b required 01", name, {sort_rst, in_ready}); end
        frame_q.delete();
    endtask

    task automatic test_reset();
        synrst = 1'b1; in_valid = 1'b1; in_data = 12'h5A5; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        n_checks++; if ({in_ready, sort_en, sort_rst, out_valid} !== 4'b0010) begin n_fail++; $display("FAIL reset ctrl: got rdy/en/srst/ovld=%b required 0010", {in_ready, sort_en, sort_rst, out_valid}); end
        n_checks++; if ({out_max, out_sum, out_mean, out_count, out_short, out_timeout} !== '0) begin n_fail++; $display("FAIL reset outs: got max=%0d sum=%0d cnt=%0d required 0", out_max, out_sum, out_count); end
        n_checks++; if (sort_data !== 12'h5A5) begin n_fail++; $display("FAIL reset sort_data: got %h required 5a5", sort_data); end
        synrst = 1'b0; in_valid = 1'b0; #1;
        n_checks++; if ({sort_rst, in_ready} !== 2'b10) begin n_fail++; $display("FAIL reset clear cycle: got srst/rdy=%b required 10", {sort_rst, in_ready}); end
        tick();
        n_checks++; if ({sort_rst, in_ready} !== 2'b01) begin n_fail++; $display("FAIL reset run: got srst/rdy=%b required 01", {sort_rst, in_ready}); end
    endtask

    task automatic test_frame_ramp();
        for (int i = 1; i <= 20; i++) send(W'(i), (i == 20), 1'b0);
        finish_frame("ramp", 1, 1'b0);
    endtask

    task automatic test_short_frame();
        send(12'd100, 1'b0, 1'b0);
        send(12'd7, 1'b0, 1'b0);
        send(12'd50, 1'b1, 1'b0);
        finish_frame("short3", 1, 1'b0);
        send(W'($urandom), 1'b1, 1'b0);
        finish_frame("single", 1, 1'b0);
    endtask

    task automatic test_hold();
        int n;
        n = $urandom_range(2, 24);
        for (int i = 0; i < n; i++) send(W'($urandom), (i == n - 1), 1'b0);
        finish_frame("hold10", 10, 1'b0);
    endtask

    task automatic test_synrst_midframe();
        for (int i = 0; i < 5; i++) send(W'($urandom_range(1, 4095)), 1'b0, 1'b0);
        synrst = 1'b1;
        tick();
        n_checks++; if ({out_valid, in_ready, sort_en, sort_rst} !== 4'b0001) begin n_fail++; $display("FAIL midrst ctrl: got ovld/rdy/en/srst=%b required 0001", {out_valid, in_ready, sort_en, sort_rst}); end
        n_checks++; if ({out_max, out_sum, out_count, out_short} !== '0) begin n_fail++; $display("FAIL midrst outs: got max=%0d sum=%0d cnt=%0d required 0", out_max, out_sum, out_count); end
        tick();
        synrst = 1'b0;
        tick();
        frame_q.delete();
        for (int i = 0; i < 16; i++) send(12'hFFF, (i == 15), 1'b0);
        finish_frame("full_fff", 1, 1'b0);
    endtask

    task automatic test_gaps();
        int en0;
        en0 = en_cnt;
        send(12'd9, 1'b0, 1'b1);
        send(12'd3, 1'b0, 1'b1);
        send(12'd9, 1'b1, 1'b1);
        n_checks++; if (en_cnt - en0 !== 3) begin n_fail++; $display("FAIL gaps sort_en pulses: got %0d required 3", en_cnt - en0); end
        finish_frame("gaps", 2, 1'b0);
    endtask

    task automatic test_reset_in_hold();
        int n;
        n = $urandom_range(1, 20);
        for (int i = 0; i < n; i++) send(W'($urandom_range(1, 4095)), (i == n - 1), 1'b0);
        tick(); tick();
        synrst = 1'b1;
        tick();
        n_checks++; if ({out_valid, out_max, out_sum, out_count} !== '0) begin n_fail++; $display("FAIL holdrst outs: got ovld=%0b max=%0d cnt=%0d required 0", out_valid, out_max, out_count); end
        synrst = 1'b0;
        tick();
        n_checks++; if ({sort_rst, in_ready} !== 2'b01) begin n_fail++; $display("FAIL holdrst rerun: got srst/rdy=%b required 01", {sort_rst, in_ready}); end
        frame_q.delete();
    endtask

    task automatic test_idle_empty();
        bit bad;
        bad = 1'b0;
        in_valid = 1'b0;
        repeat (3 * TO) begin
            tick();
            if (in_ready !== 1'b1 || out_valid !== 1'b0) bad = 1'b1;
        end
        n_checks++; if (bad) begin n_fail++; $display("FAIL idle_empty: got early frame close, required RUN held"); end
    endtask

`ifdef SORT16_FRAME_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        send(12'd4, 1'b0, 1'b0);
        send(12'd6, 1'b0, 1'b0);
        k = 0;
        while (in_ready === 1'b1 && k < 40) begin tick(); k++; end
        n_checks++; if (k !== TO) begin n_fail++; $display("FAIL timeout idle cycles: got %0d required %0d", k, TO); end
        finish_frame("timeout", 1, 1'b1);
    endtask
`else
    task automatic test_timeout();
        bit bad;
        send(12'd11, 1'b0, 1'b0);
        send(12'd22, 1'b0, 1'b0);
        bad = 1'b0;
        repeat (4 * TO) begin
            tick();
            if (in_ready !== 1'b1 || out_valid !== 1'b0) bad = 1'b1;
        end
        n_checks++; if (bad) begin n_fail++; $display("FAIL no_timeout: got frame closed while idle, required RUN held"); end
        send(12'd33, 1'b1, 1'b0);
        finish_frame("no_timeout", 1, 1'b0);
    endtask
`endif

    task automatic test_random();
        int lens[6];
        int n;
        lens = '{1, 17, 33, 5, 16, 40};
        for (int f = 0; f < 6; f++) begin
            n = lens[f];
            for (int i = 0; i < n; i++) send(W'($urandom), (i == n - 1), 1'($urandom_range(0, 1)));
            finish_frame($sformatf("rand%0d", f), $urandom_range(1, 4), 1'b0);
        end
    endtask

    initial begin
        synrst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        test_reset();
        test_frame_ramp();
        test_short_frame();
        test_hold();
        test_synrst_midframe();
        test_gaps();
        test_reset_in_hold();
        test_idle_empty();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
